// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: funct3 access codes
// and the controller state encoding.
package load_store_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-oriented memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, byte enables, store-lane
// replication and load-lane extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        be         = '0;
        lane_wdata = wdata;
        load_data  = '0;
        bad        = 1'b0;
        case (funct3)
            LB: begin
                be         = we ? (4'b0001 << addr_lo) : '1;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {{24{byte_v[7]}}, byte_v};
            end
            LH: begin
                bad        = addr_lo[0];
                be         = we ? (addr_lo[1] ? 4'b1100 : 4'b0011) : '1;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {{16{half_v[15]}}, half_v};
            end
            LW: begin
                bad       = (addr_lo != 2'b00);
                be        = '1;
                load_data = mem_rdata;
            end
            LBU: begin
                bad       = we;
                be        = '1;
                load_data = {24'd0, byte_v};
            end
            LHU: begin
                bad       = we | addr_lo[0];
                be        = '1;
                load_data = {16'd0, half_v};
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: accepts one access per start pulse, drives the
// memory bus until ack, then reports done (or done+fault for bad accesses).
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    we,
    input  logic [2:0]              funct3,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             rdata,
    output logic                    fault,
    load_store_unit_if.master       mem
);

    lsu_state_t  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        al_idle;
    logic [2:0]  al_funct3;
    logic        al_we;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_bad;

    // The aligner checks the incoming request in IDLE and the latched one afterwards.
    assign al_idle    = (state_q == IDLE);
    assign al_funct3  = al_idle ? funct3    : funct3_q;
    assign al_we      = al_idle ? we        : we_q;
    assign al_addr_lo = al_idle ? addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .we         (al_we),
        .addr_lo    (al_addr_lo),
        .wdata      (wdata),
        .mem_rdata  (mem.mem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load),
        .bad        (al_bad)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        addr_lo_d   = addr_lo_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (al_bad) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        funct3_d    = funct3;
                        we_d        = we;
                        addr_lo_d   = addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = we;
                        mem_be_d    = al_be;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = '0;
                    if (!we_q) begin
                        rdata_d = al_load;
                    end
                end
            end
            RESP: state_d = IDLE;
            ERR:  state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            addr_lo_q   <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            addr_lo_q   <= addr_lo_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// transactions and completions; negedge monitors pop and compare.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          hold;
    } memx_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;

    load_store_unit_if mif ();

    load_store_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata),
        .fault  (fault),
        .mem    (mif.master)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    resp_t exp_q[$];
    memx_t mem_q[$];
    memx_t cur;
    logic  have_cur = 1'b0;
    logic  req_prev = 1'b0;
    int    hold = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory-bus monitor and completion monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (mif.mem_req) begin
                if (!req_prev) begin
                    hold = 0;
                    if (mem_q.size() == 0) begin
                        total++; bad++; have_cur = 1'b0;
                        $display("FAIL unexpected_mem_req: got req at addr %h expected none", mif.mem_addr);
                    end else begin
                        cur = mem_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                hold++;
                if (have_cur) begin
                    chk("mem_addr", mif.mem_addr, cur.addr);
                    chk("mem_be", {28'd0, mif.mem_be}, {28'd0, cur.be});
                    chk("mem_we", {31'd0, mif.mem_we}, {31'd0, cur.we});
                    if (cur.chk_wdata) chk("mem_wdata", mif.mem_wdata, cur.wdata);
                end
            end else begin
                if (req_prev && have_cur) begin
                    chk("mem_req_hold", 32'(hold), 32'(cur.hold));
                    have_cur = 1'b0;
                end
                chk("idle_we_be", {27'd0, mif.mem_we, mif.mem_be}, 32'd0);
            end
            req_prev = mif.mem_req;

            if (done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 fault=%b expected no done", fault);
                end else begin
                    resp_t r;
                    r = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(r.cyc));
                    chk("fault", {31'd0, fault}, {31'd0, r.fault});
                    chk("rdata", rdata, r.rdata);
                end
            end else if (fault) begin
                total++; bad++;
                $display("FAIL fault_without_done: got fault=1 expected 0");
            end
        end
    end

    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] mrd, input int d, input logic is_err, input logic [31:0] exp_rd,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic pulse_mid);
        resp_t r;
        memx_t m;
        int    n;
        n       = cyc;
        r.fault = is_err;
        r.rdata = exp_rd;
        r.cyc   = is_err ? n + 1 : n + 2 + d;
        exp_q.push_back(r);
        if (!is_err) begin
            m.addr = exp_addr; m.be = exp_be; m.we = w; m.wdata = exp_wd;
            m.chk_wdata = w; m.hold = d + 1;
            mem_q.push_back(m);
        end
        start = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        if (!is_err) begin
            mif.mem_rdata = mrd;
            for (int i = 0; i < d; i++) begin
                mif.mem_ack = 1'b0;
                if (pulse_mid && i == 1) begin
                    start = 1'b1; we = 1'b0; funct3 = LW; addr = 32'h200;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            mif.mem_ack = 1'b1;
            @(posedge clk); #1;
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 32'hBAD0BAD0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mem_we_be", {27'd0, mif.mem_we, mif.mem_be}, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        //  we    f3      addr          wdata         mem_rdata     d  err   exp_rdata     exp_addr      be       exp_wdata     mid
        op(1'b0, LW,     32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        1'b0);
        op(1'b0, LB,     32'h103, 32'h0,        32'h80FF0000, 0, 1'b0, 32'hFFFFFF80, 32'h100, 4'b1111, 32'h0,        1'b0);
        op(1'b0, LBU,    32'h103, 32'h0,        32'h80FF0000, 0, 1'b0, 32'h00000080, 32'h100, 4'b1111, 32'h0,        1'b0);
        op(1'b1, LH,     32'h22,  32'h0000ABCD, 32'h0,        0, 1'b0, 32'h00000080, 32'h20,  4'b1100, 32'hABCDABCD, 1'b0);
        op(1'b0, LW,     32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h00000080, 32'h0,   4'b0000, 32'h0,        1'b0);
        op(1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h00000080, 32'h0,   4'b0000, 32'h0,        1'b0);
        op(1'b1, LW,     32'h40,  32'h12345678, 32'h0,        3, 1'b0, 32'h00000080, 32'h40,  4'b1111, 32'h12345678, 1'b1);
        op(1'b1, LB,     32'h41,  32'h000000A5, 32'h0,        1, 1'b0, 32'h00000080, 32'h40,  4'b0010, 32'hA5A5A5A5, 1'b0);
        op(1'b0, LH,     32'h106, 32'h0,        32'h80017FFF, 1, 1'b0, 32'hFFFF8001, 32'h104, 4'b1111, 32'h0,        1'b0);
        op(1'b0, LHU,    32'h104, 32'h0,        32'h80019ABC, 0, 1'b0, 32'h00009ABC, 32'h104, 4'b1111, 32'h0,        1'b0);
        op(1'b1, LBU,    32'h104, 32'h0,        32'h0,        0, 1'b1, 32'h00009ABC, 32'h0,   4'b0000, 32'h0,        1'b0);
        op(1'b0, LH,     32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h00009ABC, 32'h0,   4'b0000, 32'h0,        1'b0);
        op(1'b0, LB,     32'h101, 32'h0,        32'h00007F00, 2, 1'b0, 32'h0000007F, 32'h100, 4'b1111, 32'h0,        1'b0);
        op(1'b1, LH,     32'h10,  32'hFFFF1234, 32'h0,        0, 1'b0, 32'h0000007F, 32'h10,  4'b0011, 32'h12341234, 1'b0);
        op(1'b1, LW,     32'h13,  32'h0,        32'h0,        0, 1'b1, 32'h0000007F, 32'h0,   4'b0000, 32'h0,        1'b0);

        // Reset while waiting for ack, then a stray ack after release.
        start = 1'b1; we = 1'b0; funct3 = LW; addr = 32'h300;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_rst_mem_req", {31'd0, mif.mem_req}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mif.mem_rdata = 32'h11111111;
        mif.mem_ack   = 1'b1;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);

        op(1'b0, LW,     32'h8,   32'h0,        32'h55AA55AA, 1, 1'b0, 32'h55AA55AA, 32'h8,   4'b1111, 32'h0,        1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001: The unit SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
- REQ-002: clk  input  1  system clock; all state updates on the rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  one-cycle request from the multicycle controller, sampled only in IDLE.
- REQ-005: we  input  1  access type: 1 = store (MemWrite), 0 = load.
- REQ-006: funct3  input  3  access size and sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- REQ-007: addr  input  32  byte address (ALU result).
- REQ-008: wdata  input  32  store data (rs2).
- REQ-009: busy  output  1  high in every state other than IDLE.
- REQ-010: done  output  1  one-cycle completion pulse.
- REQ-011: rdata  output  32  extended load result.
- REQ-012: fault  output  1  one-cycle pulse coincident with done for a misaligned or illegal access.
- REQ-013: mem_req  output  1  memory request, held until mem_ack.
- REQ-014: mem_we  output  1  memory write enable.
- REQ-015: mem_addr  output  32  word address, with bits [1:0] always 0.
- REQ-016: mem_be  output  4  byte-lane enables; bit i enables byte [8i+7:8i].
- REQ-017: mem_wdata  output  32  lane-positioned store data.
- REQ-018: mem_rdata  input  32  memory read word, valid when mem_ack = 1.
- REQ-019: mem_ack  input  1  memory completion; may arrive in the same cycle mem_req first rises.

Function
- REQ-020: The unit SHALL implement the states IDLE, REQ, RESP and ERR.
- REQ-021: In IDLE, start=1 with a legal, aligned access SHALL latch addr, funct3, we and wdata, then transition to REQ.
- REQ-022: In IDLE, start=1 with a misaligned access SHALL transition to ERR, and no mem_req SHALL be issued.
  - Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠00.
- REQ-023: In IDLE, start=1 with an illegal funct3 SHALL transition to ERR.
  - Illegal funct3 values: 011, 110, 111 for any access; 100 or 101 when we=1.
- REQ-024: In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata SHALL be stable; the unit SHALL remain in REQ until mem_ack=1, then go to RESP.
- REQ-025: On the mem_ack cycle of a load, the unit SHALL capture the selected lane of mem_rdata into rdata.
  - lb/lh: sign-extended.
  - lbu/lhu: zero-extended.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
- REQ-026: In RESP, done SHALL be 1 for exactly one cycle, followed by IDLE.
- REQ-027: In ERR, done=1 and fault=1 SHALL hold for exactly one cycle, followed by IDLE; rdata SHALL be unchanged.
- REQ-028: Store byte enables SHALL be: sb → 0001 shifted left by addr[1:0]; sh → 0011 or 1100 by addr[1]; sw → 1111.
- REQ-029: mem_wdata SHALL replicate the store byte to all 4 lanes for sb, and the store halfword to both lanes for sh.
- REQ-030: For loads, mem_be SHALL be 1111.
- REQ-031: Minimum latency SHALL be start at cycle N, mem_req at N+1, with mem_ack at N+1 giving done at N+2; every wait cycle SHALL add one.
- REQ-032: start while busy=1 SHALL be ignored; mem_ack outside REQ SHALL be ignored.
- REQ-033: rdata SHALL hold its value until the next load completes; stores SHALL NOT modify rdata.
- REQ-034: Outside REQ, mem_req=0, mem_we=0 and mem_be=0000.

Reset
- REQ-035: reset SHALL force IDLE, with busy=0, done=0, fault=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0 and rdata=0.
- REQ-036: reset asserted mid-transaction SHALL drop mem_req in the same cycle, combinationally through the asynchronous clear; a late mem_ack SHALL then be ignored.

Structure
- REQ-037: A shared package SHALL hold the funct3 size constants (LB, LH, LW, LBU, LHU) and the lsu_state_t enum.
- REQ-038: Lane selection, byte-enable generation and extension SHALL reside in one combinational sub-module, lsu_align.

Verification
- REQ-039: lw, addr=0x100, mem_rdata=0xDEADBEEF, ack on first req cycle → done at N+2, rdata=0xDEADBEEF, mem_addr=0x100, mem_be=1111.
- REQ-040: lb, addr=0x103, mem_rdata=0x80FF0000 → rdata=0xFFFFFF80; lbu at the same address → rdata=0x00000080.
- REQ-041: sh, addr=0x22, wdata=0x0000ABCD → mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; rdata unchanged.
- REQ-042: lw at addr=0x102 → no mem_req, done=fault=1 at N+1; funct3=011 → same response.
- REQ-043: sw with mem_ack delayed 3 cycles → mem_req held 4 cycles with stable outputs; a start pulsed mid-wait is ignored; done is one pulse.
- REQ-044: reset asserted during REQ → mem_req=0 immediately, state IDLE; an ack after reset is released → no done.
